vedic_operand_pipe: RTL and testbench



---
 rtl/vedic_pkg.sv | 10 +
 rtl/vedic_pipe_stage.sv | 33 +++
 rtl/vedic_operand_pipe.sv | 108 ++++++++++
 tb/tb_vedic_operand_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the Vedic multiplier operand path.
package vedic_pkg;
  localparam int OPW            = 9;
  localparam int MAX_PIPE_DEPTH = 16;

  // Width of a counter that can hold every value 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/vedic_pipe_stage.sv
// One register slice of the operand pipe: a valid bit plus an (a, b) pair.
// Data loads only when a valid pair arrives, so bubbles do not toggle it.
module vedic_pipe_stage
  import vedic_pkg::*;
#(
  parameter int WIDTH = OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic             en,
  output logic             vld,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      a   <= '0;
      b   <= '0;
    end else if (en) begin
      vld <= up_valid;
      if (up_valid) begin
        a <= up_a;
        b <= up_b;
      end
    end
  end

endmodule

// File: rtl/vedic_operand_pipe.sv
// Elastic DEPTH-stage buffer for multiplier operand pairs with bubble collapse,
// synchronous flush and a registered occupancy count.
module vedic_operand_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = OPW,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_a,
  output logic [WIDTH-1:0]            out_b,
  input  logic                        flush,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int OCCW = occ_width(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
    $error("vedic_operand_pipe: DEPTH out of range 1..16");
  end

  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_en;
  logic [DEPTH-1:0] w_stage_en;
  logic [DEPTH-1:0] w_up_valid;
  logic [WIDTH-1:0] w_a    [DEPTH];
  logic [WIDTH-1:0] w_b    [DEPTH];
  logic [WIDTH-1:0] w_up_a [DEPTH];
  logic [WIDTH-1:0] w_up_b [DEPTH];
  logic             w_accept;
  logic             w_emit;
  logic [OCCW-1:0]  r_occ;

  // Ready ripples from the output side: a stage may load if empty or if the
  // stage downstream of it is loading this cycle.
  always_comb begin
    w_en = '0;
    w_en[DEPTH-1] = !w_vld[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_en[i] = !w_vld[i] || w_en[i+1];
    end
  end

  assign in_ready = w_en[0] && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_emit   = out_valid && out_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign w_up_valid[gi] = w_accept;
      assign w_up_a[gi]     = in_a;
      assign w_up_b[gi]     = in_b;
    end else begin : g_inner
      assign w_up_valid[gi] = w_vld[gi-1] && !flush;
      assign w_up_a[gi]     = w_a[gi-1];
      assign w_up_b[gi]     = w_b[gi-1];
    end

    // Flush forces every stage to load an invalid token; data registers hold.
    assign w_stage_en[gi] = w_en[gi] || flush;

    vedic_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .up_valid(w_up_valid[gi]),
      .up_a    (w_up_a[gi]),
      .up_b    (w_up_b[gi]),
      .en      (w_stage_en[gi]),
      .vld     (w_vld[gi]),
      .a       (w_a[gi]),
      .b       (w_b[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCCW'(w_accept) - OCCW'(w_emit);
    end
  end

  assign out_valid = w_vld[DEPTH-1];
  assign out_a     = w_a[DEPTH-1];
  assign out_b     = w_b[DEPTH-1];
  assign occupancy = r_occ;

  a_occ_matches_vld: assert property (@(posedge clk) disable iff (rst)
    occupancy == OCCW'($countones(w_vld)));

  a_out_stable_stall: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_a) && $stable(out_b)));

  a_upstream_hold: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_a) && $stable(in_b)));

endmodule

// File: tb/tb_vedic_operand_pipe.sv
// Self-checking bench for vedic_operand_pipe: vector table, directed corner
// sequences and randomized traffic against a queue-of-positions model.
module tb_vedic_operand_pipe;
  localparam int WIDTH = 9;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             flush;
  logic [2:0]       occupancy;

  vedic_operand_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Model: ordered list of held pairs, each tagged with its stage position.
  typedef struct {int a; int b; int pos;} ent_t;
  ent_t mq[$];
  ent_t nq[$];
  int   nlim;

  typedef struct {
    bit iv; int a; int b; bit ordy; bit fl;
    bit rdy; bit ov; int occ; int oa; int ob;
  } vec_t;
  vec_t tbl[7];

  int n_vec = 0;
  int n_err = 0;
  bit last_rdy;
  bit last_dut_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Each pair advances one position per cycle but cannot pass or share the
  // slot of the pair ahead of it; a head at the last stage leaves on out_ready.
  task automatic predict(input bit ordy);
    int   lim;
    ent_t e;
    lim = DEPTH - 1;
    nq = {};
    for (int k = 0; k < mq.size(); k++) begin
      e = mq[k];
      if (k == 0 && e.pos == DEPTH - 1 && ordy) continue;
      e.pos = (e.pos + 1 > lim) ? lim : e.pos + 1;
      nq.push_back(e);
      lim = e.pos - 1;
    end
    nlim = lim;
  endtask

  task automatic do_cycle(input bit iv, input int a, input int b, input bit ordy, input bit fl);
    bit   exp_rdy;
    bit   exp_ov;
    ent_t e;
    in_valid  = iv;
    in_a      = WIDTH'(a);
    in_b      = WIDTH'(b);
    out_ready = ordy;
    flush     = fl;
    #1;
    predict(ordy);
    exp_rdy      = !fl && (nlim >= 0);
    last_rdy     = exp_rdy;
    last_dut_rdy = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (fl) begin
      mq = {};
    end else begin
      mq = nq;
      if (iv && exp_rdy) begin
        e.a = a; e.b = b; e.pos = 0;
        mq.push_back(e);
      end
    end
    #1;
    exp_ov = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    if (exp_ov) begin
      chk("out_a", 32'(out_a), 32'(mq[0].a));
      chk("out_b", 32'(out_b), 32'(mq[0].b));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit hold;
    int ha, hb;
    bit iv, ordy, fl;
    int ra, rb;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_out_a", 32'(out_a), 0);
    chk("rst_out_b", 32'(out_b), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Stream (1,2),(3,4),(5,6) with out_ready=1.
    tbl[0] = '{1, 1, 2, 1, 0, 1, 0, 1, 0, 0};
    tbl[1] = '{1, 3, 4, 1, 0, 1, 0, 2, 0, 0};
    tbl[2] = '{1, 5, 6, 1, 0, 1, 0, 3, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 0, 1, 1, 3, 1, 2};
    tbl[4] = '{0, 0, 0, 1, 0, 1, 1, 2, 3, 4};
    tbl[5] = '{0, 0, 0, 1, 0, 1, 1, 1, 5, 6};
    tbl[6] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    for (int t = 0; t < 7; t++) begin
      do_cycle(tbl[t].iv, tbl[t].a, tbl[t].b, tbl[t].ordy, tbl[t].fl);
      chk("tbl_in_ready", 32'(last_dut_rdy), 32'(tbl[t].rdy));
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[t].ov));
      chk("tbl_occupancy", 32'(occupancy), 32'(tbl[t].occ));
      if (tbl[t].ov) begin
        chk("tbl_out_a", 32'(out_a), 32'(tbl[t].oa));
        chk("tbl_out_b", 32'(out_b), 32'(tbl[t].ob));
      end
    end

    // Back-pressure fill: 4 accepted, 5th held until release.
    for (int k = 0; k < 4; k++) do_cycle(1, 10 + k, 20 + k, 0, 0);
    do_cycle(1, 14, 24, 0, 0);
    chk("bp_in_ready_full", 32'(last_dut_rdy), 0);
    chk("bp_occupancy", 32'(occupancy), 4);
    do_cycle(1, 14, 24, 0, 0);
    chk("bp_frozen_a", 32'(out_a), 10);
    chk("bp_frozen_b", 32'(out_b), 20);
    do_cycle(1, 14, 24, 1, 0);
    chk("bp_release_accept", 32'(last_dut_rdy), 1);
    for (int k = 0; k < 6; k++) do_cycle(0, 0, 0, 1, 0);
    chk("bp_drained", 32'(occupancy), 0);

    // Bubble collapse under out_ready=0.
    do_cycle(1, 7, 8, 0, 0);
    do_cycle(0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0);
    do_cycle(1, 9, 10, 0, 0);
    do_cycle(0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0);
    chk("bubble_head_a", 32'(out_a), 7);
    chk("bubble_occupancy", 32'(occupancy), 2);

    // Full pass-through: Accept and Emit together.
    do_cycle(1, 30, 31, 0, 0);
    do_cycle(1, 32, 33, 0, 0);
    chk("full_occupancy", 32'(occupancy), 4);
    do_cycle(1, 34, 35, 1, 0);
    chk("pass_in_ready", 32'(last_dut_rdy), 1);
    chk("pass_occupancy", 32'(occupancy), 4);

    // Flush with occupancy 3 and an offered pair.
    do_cycle(0, 0, 0, 1, 0);
    chk("pre_flush_occ", 32'(occupancy), 3);
    do_cycle(1, 99, 98, 0, 1);
    chk("flush_in_ready", 32'(last_dut_rdy), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_occupancy", 32'(occupancy), 0);
    do_cycle(0, 0, 0, 0, 0);

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 3; k++) do_cycle(1, 40 + k, 50 + k, 0, 0);
    do_cycle(0, 0, 0, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_occupancy", 32'(occupancy), 0);
    chk("arst_out_a", 32'(out_a), 0);
    chk("arst_out_b", 32'(out_b), 0);
    mq = {};
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    do_cycle(1, 511, 511, 1, 0);
    for (int k = 0; k < 3; k++) do_cycle(0, 0, 0, 1, 0);
    chk("max_out_valid", 32'(out_valid), 1);
    chk("max_out_a", 32'(out_a), 511);
    chk("max_out_b", 32'(out_b), 511);

    // Randomized traffic, honouring the upstream hold rule.
    hold = 0; ha = 0; hb = 0;
    for (int c = 0; c < 600; c++) begin
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 39) == 0);
      if (hold) begin
        iv = 1; ra = ha; rb = hb;
      end else begin
        iv = ($urandom_range(0, 3) != 0);
        ra = int'($urandom_range(0, 511));
        rb = int'($urandom_range(0, 511));
      end
      do_cycle(iv, ra, rb, ordy, fl);
      hold = iv && !last_rdy && !fl;
      ha = ra; hb = rb;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
